// File: rtl/button_pulser.sv
// Push-button front end: per channel 2-flop synchronizer, counter debounce and
// a registered single-cycle pulse on every accepted press (debounced 0->1).
module button_pulser #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] pulse,
  output logic [N_BTN-1:0] btn_level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] s1;
  logic [N_BTN-1:0] s2;
  logic [CNT_W-1:0] cnt     [N_BTN];
  logic [CNT_W-1:0] cnt_nxt [N_BTN];
  logic [N_BTN-1:0] level_nxt;
  logic [N_BTN-1:0] rise_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // The count only runs while the synchronized level disagrees with the
  // accepted level; any agreement restarts it, which is the glitch filter.
  always_comb begin
    level_nxt = btn_level;
    rise_nxt  = '0;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_nxt[i] = '0;
      if (s2[i] == btn_level[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == CNT_LAST) begin
        level_nxt[i] = s2[i];
        rise_nxt[i]  = s2[i];
      end else begin
        cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_BTN; i++) begin
        cnt[i] <= '0;
      end
      btn_level <= '0;
      pulse     <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      btn_level <= level_nxt;
      pulse     <= rise_nxt;
    end
  end

endmodule
